// File: rtl/morningjava_seg7_scan.sv
// morningjava_seg7_scan: time-multiplexed 7-segment driver with frame-synchronous shadow, dead time and leading-zero blanking.
// Define SEG7_BRIGHTNESS_EN to add a 3-bit brightness input that shortens the on-time within each digit slot.
module morningjava_seg7_scan #(
    parameter int DIGITS     = 4,
    parameter int SCAN_DIV   = 1024,
    parameter int ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  lz_blank,
`ifdef SEG7_BRIGHTNESS_EN
    input  logic [2:0]            brightness,
`endif
    output logic [7:0]            segments,
    output logic [DIGITS-1:0]     digit_sel,
    output logic                  frame_done
);
    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
    localparam logic POL = (ACTIVE_LOW != 0);

    logic [PW-1:0]         pre_cnt_q, pre_cnt_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [4*DIGITS-1:0]   pending_q, active_q, nib_shift;
    logic [DIGITS-1:0]     pending_dp_q, active_dp_q, dp_shift, sel_d, digit_sel_q;
    logic                  pending_valid_q, frame_done_q, pre_wrap, idx_last, boundary, on, blank;
    logic [7:0]            seg_d, segments_q;

    always_comb begin
        pre_wrap  = pre_cnt_q == PW'(SCAN_DIV - 1);
        idx_last  = idx_q == IW'(DIGITS - 1);
        boundary  = pre_wrap && idx_last;
        pre_cnt_d = pre_wrap ? '0 : pre_cnt_q + 1'b1;
        idx_d     = pre_wrap ? (idx_last ? '0 : idx_q + 1'b1) : idx_q;
        nib_shift = active_q >> {idx_q, 2'b00};
        dp_shift  = active_dp_q >> idx_q;
        // Everything from the current digit upward being zero marks a leading zero.
        blank     = lz_blank && (idx_q != '0) && (nib_shift == '0);
`ifdef SEG7_BRIGHTNESS_EN
        on        = (pre_cnt_q != '0) && (int'(pre_cnt_q) < (int'(brightness) + 1) * (SCAN_DIV / 8));
`else
        on        = pre_cnt_q != '0;
`endif
        seg_d     = on ? {dp_shift[0], blank ? 7'h00 : DEC[nib_shift[3:0]]} : 8'h00;
        sel_d     = on ? DIGITS'(1) << idx_q : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q       <= '0;
            idx_q           <= '0;
            pending_q       <= '0;
            pending_dp_q    <= '0;
            pending_valid_q <= 1'b0;
            active_q        <= '0;
            active_dp_q     <= '0;
            segments_q      <= {8{POL}};
            digit_sel_q     <= {DIGITS{POL}};
            frame_done_q    <= 1'b0;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            idx_q        <= idx_d;
            frame_done_q <= boundary;
            segments_q   <= seg_d ^ {8{POL}};
            digit_sel_q  <= sel_d ^ {DIGITS{POL}};
            if (load && boundary) begin
                active_q        <= value;
                active_dp_q     <= dp_in;
                pending_valid_q <= 1'b0;
            end else if (load) begin
                pending_q       <= value;
                pending_dp_q    <= dp_in;
                pending_valid_q <= 1'b1;
            end else if (boundary && pending_valid_q) begin
                active_q        <= pending_q;
                active_dp_q     <= pending_dp_q;
                pending_valid_q <= 1'b0;
            end
        end
    end

    assign segments   = segments_q;
    assign digit_sel  = digit_sel_q;
    assign frame_done = frame_done_q;
endmodule

// File: tb/tb_morningjava_seg7_scan.sv
// tb_morningjava_seg7_scan: directed frame-by-frame checks of the 4-digit scanner, plus a common-anode instance.
module tb_morningjava_seg7_scan;
    logic        clk = 1'b0, rst_n = 1'b0, load = 1'b0, lz_blank = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dp_in = '0;
    logic [7:0]  segments, seg_al;
    logic [3:0]  digit_sel, sel_al;
    logic        frame_done, fd_al;
    int          checks = 0, failures = 0, n;

    always #5 clk = ~clk;

    morningjava_seg7_scan #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(0)) u_dut (
        .clk(clk), .rst_n(rst_n), .load(load), .value(value), .dp_in(dp_in), .lz_blank(lz_blank),
        .segments(segments), .digit_sel(digit_sel), .frame_done(frame_done));

    morningjava_seg7_scan #(.DIGITS(4), .SCAN_DIV(4), .ACTIVE_LOW(1)) u_dut_al (
        .clk(clk), .rst_n(rst_n), .load(load), .value(16'h0001), .dp_in(4'b0000), .lz_blank(1'b0),
        .segments(seg_al), .digit_sel(sel_al), .frame_done(fd_al));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at the negedge where frame_done is high; samples the 16 cycles of the next frame.
    task automatic frame(input string tag, input logic [31:0] segs, input int c1 = -1, input logic [15:0] v1 = '0,
                         input int c2 = -1, input logic [15:0] v2 = '0, input logic [3:0] dp = '0);
        logic [3:0] es;
        check({tag, "_fd_start"}, 32'(frame_done), 1);
        for (int j = 0; j < 16; j++) begin
            load  = (j == c1) || (j == c2);
            value = (j == c2) ? v2 : v1;
            dp_in = dp;
            @(negedge clk);
            es = 4'b0001 << (j / 4);
            if (j % 4 == 0) begin
                check($sformatf("%s_dead_seg%0d", tag, j), 32'(segments), 0);
                check($sformatf("%s_dead_sel%0d", tag, j), 32'(digit_sel), 0);
            end else begin
                check($sformatf("%s_seg%0d", tag, j), 32'(segments), 32'(segs[8*(j/4) +: 8]));
                check($sformatf("%s_sel%0d", tag, j), 32'(digit_sel), 32'(es));
            end
            if (j == 7) check({tag, "_fd_mid"}, 32'(frame_done), 0);
        end
        load = 1'b0;
    endtask

    initial begin
        logic [7:0] eseg;
        logic [3:0] esel;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("rst_seg", 32'(segments), 0);
        check("rst_sel", 32'(digit_sel), 0);
        check("rst_fd", 32'(frame_done), 0);
        check("rst_seg_al", 32'(seg_al), 32'hFF);
        check("rst_sel_al", 32'(sel_al), 32'hF);
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (!frame_done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("rst_first_fd", n, 16);

        frame("pre", {4{8'h3F}}, 2, 16'h12AF, -1, 16'h0, 4'b0100);
        frame("basic", 32'h06DB7771);
        frame("hold", 32'h06DB7771, 5, 16'h0000, 7, 16'h8888);
        frame("new", {4{8'h7F}});
        lz_blank = 1'b1;
        frame("lzpre", {4{8'h7F}}, 3, 16'h0050);
        frame("lz", 32'h00006D3F, 3, 16'h0000);
        frame("lz0", 32'h0000003F);
        lz_blank = 1'b0;
        frame("bdpre", {4{8'h3F}}, 15, 16'hC0DE);
        check("bd_pending_valid", 32'(u_dut.pending_valid_q), 0);
        frame("bd", 32'h393F5E79);

        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            eseg = (j % 4 == 0) ? 8'hFF : ~((j / 4 == 0) ? 8'h06 : 8'h3F);
            esel = (j % 4 == 0) ? 4'hF : ~(4'b0001 << (j / 4));
            check($sformatf("al_seg%0d", j), 32'(seg_al), 32'(eseg));
            check($sformatf("al_sel%0d", j), 32'(sel_al), 32'(esel));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
